// File: rtl/dac_spi_tx.sv
// Drives a 12-bit SPI DAC: saturates a signed sample, offset-binary encodes it, shifts a 16-bit frame MSB first.
// Latency: sync_n falls the cycle after start is accepted; busy lasts 34*CLK_DIV cycles; start is ignored while busy.
module dac_spi_tx #(
  parameter int cant_bits = 13,
  parameter int CLK_DIV   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [cant_bits-1:0] dato_in,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        sync_n,
  output logic                        sclk,
  output logic                        sdin
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic signed [cant_bits-1:0] SAT_HI = cant_bits'(2047);
  localparam logic signed [cant_bits-1:0] SAT_LO = cant_bits'(-2048);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t       state, state_d;
  logic [CW-1:0] hcnt, hcnt_d;
  logic [4:0]   ph, ph_d;
  logic [14:0]  shreg, shreg_d;
  logic         sync_n_d, sclk_d, sdin_d, busy_d, done_d;
  logic [11:0]  sat;
  logic [15:0]  frame;
  logic         half_end;

  always_comb begin
    if (dato_in > SAT_HI)      sat = 12'h7FF;
    else if (dato_in < SAT_LO) sat = 12'h800;
    else                       sat = dato_in[11:0];
    frame = {4'b0000, ~sat[11], sat[10:0]};
  end

  assign half_end = (hcnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hcnt   <= '0;
      ph     <= '0;
      shreg  <= '0;
      sync_n <= 1'b1;
      sclk   <= 1'b1;
      sdin   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      hcnt   <= hcnt_d;
      ph     <= ph_d;
      shreg  <= shreg_d;
      sync_n <= sync_n_d;
      sclk   <= sclk_d;
      sdin   <= sdin_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (half_end && ph == 5'd31) state_d = GAP;
      GAP:     if (half_end && ph == 5'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ph counts SCLK half-periods: even = high, odd = low; ends at the 32nd half-period
  always_comb begin
    hcnt_d   = hcnt;
    ph_d     = ph;
    shreg_d  = shreg;
    sync_n_d = sync_n;
    sclk_d   = sclk;
    sdin_d   = sdin;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        hcnt_d = '0;
        ph_d   = '0;
        if (start) begin
          shreg_d  = frame[14:0];
          sdin_d   = frame[15];
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        hcnt_d = half_end ? '0 : hcnt + 1'b1;
        if (half_end) begin
          ph_d = ph + 5'd1;
          if (!ph[0]) begin
            sclk_d = 1'b0;
          end else if (ph == 5'd31) begin
            sync_n_d = 1'b1;
            sclk_d   = 1'b1;
            sdin_d   = 1'b0;
            ph_d     = '0;
          end else begin
            sclk_d  = 1'b1;
            sdin_d  = shreg[14];
            shreg_d = {shreg[13:0], 1'b0};
          end
        end
      end
      GAP: begin
        hcnt_d = half_end ? '0 : hcnt + 1'b1;
        if (half_end) begin
          if (ph == 5'd1) begin
            ph_d   = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            ph_d = ph + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a CLK_DIV=4 instance and a CLK_DIV=1 instance driven through shared stimulus.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst0, rst1, sel, st;
  logic signed [12:0] dv;
  logic start0, start1;
  logic busy0, done0, sync_n0, sclk0, sdin0;
  logic busy1, done1, sync_n1, sclk1, sdin1;
  logic m_busy, m_done, m_sync, m_sclk, m_sdin;

  int checks = 0;
  int errors = 0;

  assign start0 = st & ~sel;
  assign start1 = st & sel;
  assign m_busy = sel ? busy1   : busy0;
  assign m_done = sel ? done1   : done0;
  assign m_sync = sel ? sync_n1 : sync_n0;
  assign m_sclk = sel ? sclk1   : sclk0;
  assign m_sdin = sel ? sdin1   : sdin0;

  dac_spi_tx #(.cant_bits(13), .CLK_DIV(4)) dut0 (
    .clk(clk), .rst(rst0), .dato_in(dv), .start(start0),
    .busy(busy0), .done(done0), .sync_n(sync_n0), .sclk(sclk0), .sdin(sdin0)
  );

  dac_spi_tx #(.cant_bits(13), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .dato_in(dv), .start(start1),
    .busy(busy1), .done(done1), .sync_n(sync_n1), .sclk(sclk1), .sdin(sdin1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one frame on the selected instance; the bench samples on negedges.
  task automatic send(input logic signed [12:0] v, input bit poke,
                      output logic [15:0] fr, output int low, output int bsy,
                      output int dn_at, output int falls);
    logic ps;
    fr = '0; low = 0; bsy = 0; dn_at = -1; falls = 0; ps = 1'b1;
    @(negedge clk);
    dv = v; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    dv = ~v;
    for (int c = 0; c < 400; c++) begin
      if (!m_sync) low++;
      if (m_busy) bsy++;
      if (ps && !m_sclk && !m_sync) begin
        fr = {fr[14:0], m_sdin};
        falls++;
      end
      ps = m_sclk;
      if (m_done) begin
        dn_at = c;
        break;
      end
      if (poke) st = (c >= 10 && c < 13) || c == 100;
      @(negedge clk);
    end
    st = 1'b0;
  endtask

  typedef struct {
    logic signed [12:0] dato;
    logic [15:0]        exp_frame;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] fr;
    int low, bsy, dn_at, falls;
    int fi, hi, dones, lows;
    logic ps, psync;
    logic [15:0] b2b_exp[3];

    vecs[0] = '{13'sd0,     16'h0800};
    vecs[1] = '{13'sd4095,  16'h0FFF};
    vecs[2] = '{-13'sd4096, 16'h0000};
    vecs[3] = '{-13'sd1,    16'h07FF};
    vecs[4] = '{13'sd2047,  16'h0FFF};
    vecs[5] = '{-13'sd2048, 16'h0000};
    vecs[6] = '{13'sd2048,  16'h0FFF};
    vecs[7] = '{-13'sd2049, 16'h0000};
    vecs[8] = '{13'sd1,     16'h0801};
    vecs[9] = '{13'sd100,   16'h0864};
    b2b_exp[0] = 16'h0900;
    b2b_exp[1] = 16'h0700;
    b2b_exp[2] = 16'h0805;

    sel = 1'b0; st = 1'b0; dv = '0; rst0 = 1'b0; rst1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sync_n", int'(sync_n0), 1);
    chk("rst_sclk",   int'(sclk0),   1);
    chk("rst_sdin",   int'(sdin0),   0);
    chk("rst_busy",   int'(busy0),   0);
    chk("rst_done",   int'(done0),   0);
    chk("rst1_sync_n", int'(sync_n1), 1);
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].dato, 1'b0, fr, low, bsy, dn_at, falls);
      chk($sformatf("v%0d_frame", i), int'(fr), int'(vecs[i].exp_frame));
      chk($sformatf("v%0d_falls", i), falls, 16);
      chk($sformatf("v%0d_low", i),   low,   128);
      chk($sformatf("v%0d_busy", i),  bsy,   136);
      chk($sformatf("v%0d_done", i),  dn_at, 136);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), int'(done0), 0);
    end

    // start pokes during busy must not add frames or done pulses
    send(13'sd0, 1'b1, fr, low, bsy, dn_at, falls);
    chk("poke_frame", int'(fr), 16'h0800);
    chk("poke_done",  dn_at, 136);
    lows = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sync_n0) lows++;
      if (done0) dones++;
    end
    chk("poke_extra_low",  lows,  0);
    chk("poke_extra_done", dones, 0);

    // back-to-back frames with start held high
    fi = 0; hi = 0; dones = 0; ps = 1'b1; psync = 1'b1; fr = '0;
    @(negedge clk);
    dv = 13'sd256; st = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (done0) dones++;
      if (psync && !sync_n0) begin
        if (fi > 0) chk($sformatf("b2b_gap%0d", fi), hi, 9);
        fr = '0;
        case (fi)
          0:       dv = -13'sd256;
          1:       dv = 13'sd5;
          default: st = 1'b0;
        endcase
      end
      if (sync_n0) hi++; else hi = 0;
      if (ps && !sclk0 && !sync_n0) fr = {fr[14:0], sdin0};
      if (!psync && sync_n0 && fi < 3) begin
        chk($sformatf("b2b_frame%0d", fi), int'(fr), int'(b2b_exp[fi]));
        fi++;
      end
      ps = sclk0; psync = sync_n0;
      if (fi == 3 && done0) break;
    end
    st = 1'b0;
    chk("b2b_frames", fi, 3);
    chk("b2b_dones", dones, 3);

    // reset after the 7th falling edge
    falls = 0; ps = 1'b1; lows = 0;
    @(negedge clk);
    dv = 13'sd1000; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    for (int c = 0; c < 200 && falls < 7; c++) begin
      if (ps && !sclk0 && !sync_n0) falls++;
      ps = sclk0;
      if (falls < 7) @(negedge clk);
    end
    chk("mid_falls", falls, 7);
    rst0 = 1'b0;
    #1;
    chk("mid_rst_sync_n", int'(sync_n0), 1);
    chk("mid_rst_sclk",   int'(sclk0),   1);
    chk("mid_rst_sdin",   int'(sdin0),   0);
    chk("mid_rst_busy",   int'(busy0),   0);
    @(negedge clk);
    rst0 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sync_n0 || busy0) lows++;
    end
    chk("mid_no_resume", lows, 0);
    send(-13'sd1, 1'b0, fr, low, bsy, dn_at, falls);
    chk("post_rst_frame", int'(fr), 16'h07FF);
    chk("post_rst_done",  dn_at, 136);

    // CLK_DIV=1 instance
    sel = 1'b1;
    send(13'sd0, 1'b0, fr, low, bsy, dn_at, falls);
    chk("d1_frame", int'(fr), 16'h0800);
    chk("d1_falls", falls, 16);
    chk("d1_low",   low,   32);
    chk("d1_busy",  bsy,   34);
    chk("d1_done",  dn_at, 34);
    send(13'sd3000, 1'b0, fr, low, bsy, dn_at, falls);
    chk("d1_sat_frame", int'(fr), 16'h0FFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Serial transmitter that drives a 12-bit SPI DAC (DAC121S101-class: SYNC, SCLK, DIN) from the signed 13-bit sample format used in the servo datapath. It is the output-side counterpart of the ADC capture chain. It saturates the signed sample to 12 bits, converts it to offset binary and shifts out one 16-bit frame, MSB first, per start request.

Parameters:
cant_bits, 13, width of signed input sample
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
dato_in  input  cant_bits  signed sample; captured on an accepted start
start  input  1  request one frame; accepted only when busy=0
busy  output  1  high from the cycle after acceptance until the frame and gap complete
done  output  1  one-cycle pulse at frame completion
sync_n  output  1  DAC SYNC, active low
sclk  output  1  serial clock, idles high
sdin  output  1  serial data to DAC

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sync_n=1, sclk=1, sdin=0, busy=0, done=0, counters=0. Takes effect immediately, including mid-frame; no partial frame resumes after release.
- Conversion at acceptance, registered into shift register:
  - saturate dato_in to [-2048, 2047];
  - payload = saturated value + 2048 (MSB inverted), 12 bits;
  - frame = {4'b0000 (normal mode, PD=00), payload}.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: sync_n=1, sclk=1, busy=0. If start=1, capture the frame. Next cycle: SHIFT, sync_n=0, busy=1, sdin=frame[15].
- SHIFT:
  - Half-period counter counts CLK_DIV cycles per SCLK level, beginning with sclk high.
  - Falling edge k (k=1..16) occurs CLK_DIV*(2k-1) cycles after sync_n falls; the DAC samples sdin there.
  - sdin advances to the next bit on each rising edge (edges 1..15).
  - After the 16th falling edge and CLK_DIV low cycles: sclk returns high and sync_n returns high in the same cycle, then GAP.
  - sync_n low width is exactly 32*CLK_DIV cycles.
- GAP: sync_n=1, sclk=1, sdin=0 for 2*CLK_DIV cycles. Then IDLE with done=1 for that single cycle and busy=0 in the same cycle.
- Total busy time is 34*CLK_DIV cycles (136 for the default).
- start while busy=1: ignored, no queuing. start in the done cycle: accepted (busy=0), and the next frame begins the following cycle.
- dato_in changes during a frame have no effect.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- dato_in=0, start pulse -> 16 bits captured at sclk falling edges = 0x0800; sync_n low 128 cycles; done 136 cycles after the start cycle+1.
- dato_in=+4095 -> saturates, frame 0x0FFF; dato_in=-4096 -> frame 0x0000; dato_in=-1 -> 0x07FF; dato_in=+2047 -> 0x0FFF.
- start held high continuously with alternating dato_in -> frames back-to-back; sync_n high exactly 2*CLK_DIV+1 cycles between frames; each frame carries the value present at its acceptance cycle.
- start pulses during busy -> no extra frames, no done pulses beyond one per accepted frame.
- rst asserted after the 7th falling edge -> same-edge sync_n=1, sclk=1, sdin=0, busy=0. After release, a new start produces a complete, correct frame.
- CLK_DIV=1 build -> sclk period 2 cycles, 16 falling edges, busy 34 cycles, frame 0x0800 for dato_in=0.
